stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Stopwatch sequencer. Consumes the level clocks from clk_div (clk_1Hz, clk_2Hz, clk_blink) as data.
//  Edge-detects them in the clk_in domain and runs the RUN/STOP/ADJ state machine.
//  Owns the MM:SS counters that feed the display mux, plus blanking flags for the adjust-mode blink.
// PARAMETERS
//  CNT_W    6   width of minutes/seconds counters
//  MAX_SEC  59  last seconds value before wrap
//  MAX_MIN  59  last minutes value before wrap
// PORTS
//  clk_in     in   1      system clock; the only clock, all logic on its posedge
//  rst        in   1      synchronous, active-high reset
//  clk_1Hz    in   1      level from clk_div; rising edge = count tick
//  clk_2Hz    in   1      level from clk_div; rising edge = adjust tick
//  clk_blink  in   1      level from clk_div; high = blank selected field in ADJ
//  pause_btn  in   1      debounced button level; rising edge = press
//  adj        in   1      switch; 1 = adjust mode
//  sel        in   1      switch; 0 = adjust seconds, 1 = adjust minutes
//  minutes    out  CNT_W  current minutes, 0..MAX_MIN
//  seconds    out  CNT_W  current seconds, 0..MAX_SEC
//  running    out  1      1 while state==RUN
//  blank_min  out  1      1 = display blanks minutes digits
//  blank_sec  out  1      1 = display blanks seconds digits
//  rollover   out  1      1-cycle pulse when MAX_MIN:MAX_SEC wraps to 00:00 in RUN
// BEHAVIOUR
//  Edge detect, per input x in {clk_1Hz, clk_2Hz, pause_btn}:
//   - s <= x; s_d <= s; rise = s & ~s_d.
//   - During rst both s and s_d load x, so no spurious edge on reset release.
//   - Latency: x high before edge k -> rise high in cycle k..k+1 -> counter/state update at edge k+1.
//  clk_blink: sampled once (b <= clk_blink); no edge detect.
//  Reset (rst=1 at posedge):
//   - minutes=0, seconds=0, state=STOP, running=0, blank_*=0, rollover=0.
//   - Applies mid-operation from any state; takes effect that edge.
//  States (2-bit): STOP, RUN, ADJ.
//   - any  & adj==1           -> ADJ (highest priority; pause rise ignored that cycle)
//   - ADJ  & adj==0           -> STOP
//   - STOP & rise_pause       -> RUN
//   - RUN  & rise_pause       -> STOP
//  RUN on rise_1Hz:
//   - seconds<MAX_SEC: seconds+1.
//   - else seconds=0 and minutes+1; minutes==MAX_MIN also wraps to 0 and pulses rollover for 1 cycle.
//  STOP: counters hold. rise_1Hz ignored.
//  ADJ on rise_2Hz:
//   - sel=0: seconds+1, MAX_SEC wraps to 0, no carry into minutes.
//   - sel=1: minutes+1, MAX_MIN wraps to 0.
//   - rise_1Hz ignored.
//  Simultaneous events:
//   - rise_1Hz & rise_pause in RUN: count applied AND state -> STOP, same edge.
//   - rise_1Hz & rise_pause in STOP: no count; state -> RUN.
//   - adj rising & rise_2Hz same cycle: still leaving old state, so no adjust increment that edge.
//  Outputs are registered.
//   - blank_sec = (state==ADJ) & ~sel & b.
//   - blank_min = (state==ADJ) & sel & b.
//   - running   = (state==RUN).
//  Counters never exceed their MAX; arithmetic is CNT_W-bit, compare-then-wrap (no modulo).
// STRUCTURE
//  stopwatch_pkg: state encodings (ST_STOP, ST_RUN, ST_ADJ), default MAX_SEC/MAX_MIN, CNT_W.
//  Sub-module rise_det (s/s_d pair with reset preload), instanced for clk_1Hz, clk_2Hz, pause_btn.
//  Top holds the FSM, the two counters and the output registers.
// TESTING
//  1. rst, 3 clk_1Hz edges in STOP -> 00:00 held, running=0.
//  2. pause press, 61 clk_1Hz edges -> 01:01, running=1; 2nd press -> count frozen.
//  3. Preload 59:58, RUN, 2 ticks -> 59:59 then 00:00, rollover high exactly 1 cycle.
//  4. adj=1, sel=0, seconds=59, 1 clk_2Hz edge -> seconds=0, minutes unchanged, blank_sec follows clk_blink.
//  5. adj=1, sel=1, clk_1Hz edges only -> no change; pause press ignored; adj=0 -> STOP.
//  6. RUN with clk_1Hz held high, rst pulse 1 cycle -> 00:00, STOP, no tick after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encodings and default counter limits for the stopwatch sequencer.
package stopwatch_pkg;

    localparam int SW_CNT_W   = 6;
    localparam int SW_MAX_SEC = 59;
    localparam int SW_MAX_MIN = 59;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADJ  = 2'd2
    } state_e;

endpackage

// File: rtl/stopwatch_ctrl_rise_det.sv
// Two-flop sampler producing a one-cycle rise flag from a level input.
// Both flops preload the input during reset so releasing reset never fakes an edge.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic rise
);

    logic s_q, s_d;
    logic dly_q, dly_d;

    always_comb begin
        s_d   = x;
        dly_d = s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= x;
            dly_q <= x;
        end else begin
            s_q   <= s_d;
            dly_q <= dly_d;
        end
    end

    assign rise = s_q & ~dly_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: STOP/RUN/ADJ state machine, MM:SS counters and blink blanking flags.
// The divider levels are treated as data and edge-detected on clk_in.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CNT_W   = SW_CNT_W,
    parameter int MAX_SEC = SW_MAX_SEC,
    parameter int MAX_MIN = SW_MAX_MIN
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_1Hz,
    input  logic             clk_2Hz,
    input  logic             clk_blink,
    input  logic             pause_btn,
    input  logic             adj,
    input  logic             sel,
    output logic [CNT_W-1:0] minutes,
    output logic [CNT_W-1:0] seconds,
    output logic             running,
    output logic             blank_min,
    output logic             blank_sec,
    output logic             rollover
);

    localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(MAX_SEC);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MAX_MIN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO     = '0;

    logic rise_1hz, rise_2hz, rise_pause;

    rise_det u_rise_1hz   (.clk(clk_in), .rst(rst), .x(clk_1Hz),   .rise(rise_1hz));
    rise_det u_rise_2hz   (.clk(clk_in), .rst(rst), .x(clk_2Hz),   .rise(rise_2hz));
    rise_det u_rise_pause (.clk(clk_in), .rst(rst), .x(pause_btn), .rise(rise_pause));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic             roll_q, roll_d;
    logic             run_q, run_d;
    logic             bmin_q, bmin_d;
    logic             bsec_q, bsec_d;
    logic             b_q;

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        roll_d  = 1'b0;

        // Counter updates key off the current state, so entering ADJ never adjusts on the same edge.
        case (state_q)
            ST_RUN: begin
                if (rise_1hz) begin
                    if (sec_q < SEC_LAST) begin
                        sec_d = sec_q + ONE;
                    end else begin
                        sec_d = ZERO;
                        if (min_q < MIN_LAST) begin
                            min_d = min_q + ONE;
                        end else begin
                            min_d  = ZERO;
                            roll_d = 1'b1;
                        end
                    end
                end
                if (rise_pause) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (rise_pause) state_d = ST_RUN;
            end
            ST_ADJ: begin
                if (rise_2hz) begin
                    if (sel) min_d = (min_q < MIN_LAST) ? min_q + ONE : ZERO;
                    else     sec_d = (sec_q < SEC_LAST) ? sec_q + ONE : ZERO;
                end
                state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase

        if (adj) state_d = ST_ADJ;

        run_d  = (state_d == ST_RUN);
        bsec_d = (state_d == ST_ADJ) & ~sel & b_q;
        bmin_d = (state_d == ST_ADJ) &  sel & b_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_STOP;
            sec_q   <= ZERO;
            min_q   <= ZERO;
            roll_q  <= 1'b0;
            run_q   <= 1'b0;
            bmin_q  <= 1'b0;
            bsec_q  <= 1'b0;
            b_q     <= clk_blink;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            roll_q  <= roll_d;
            run_q   <= run_d;
            bmin_q  <= bmin_d;
            bsec_q  <= bsec_d;
            b_q     <= clk_blink;
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign running   = run_q;
    assign blank_min = bmin_q;
    assign blank_sec = bsec_q;
    assign rollover  = roll_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner sequences,
// and random stimulus compared against a total-seconds reference model.
module tb_stopwatch_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1Hz = 1'b0, clk_2Hz = 1'b0, clk_blink = 1'b0;
    logic       pause_btn = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [5:0] minutes, seconds;
    logic       running, blank_min, blank_sec, rollover;

    int nchk = 0;
    int nerr = 0;
    int roll_cnt = 0;

    stopwatch_ctrl dut (
        .clk_in(clk_in), .rst(rst),
        .clk_1Hz(clk_1Hz), .clk_2Hz(clk_2Hz), .clk_blink(clk_blink),
        .pause_btn(pause_btn), .adj(adj), .sel(sel),
        .minutes(minutes), .seconds(seconds), .running(running),
        .blank_min(blank_min), .blank_sec(blank_sec), .rollover(rollover)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: mode 0 stopped, 1 running, 2 adjusting; time kept as total seconds.
    int m_mode = 0;
    int m_total = 0;
    bit m_roll = 0, m_bmin = 0, m_bsec = 0, m_b = 0;
    bit h1_1 = 0, h2_1 = 0, h1_2 = 0, h2_2 = 0, h1_p = 0, h2_p = 0;

    task automatic model_edge();
        bit r1, r2, rp;
        int nm;
        if (rst) begin
            m_mode = 0; m_total = 0; m_roll = 0; m_bmin = 0; m_bsec = 0;
            h1_1 = clk_1Hz;   h2_1 = clk_1Hz;
            h1_2 = clk_2Hz;   h2_2 = clk_2Hz;
            h1_p = pause_btn; h2_p = pause_btn;
            m_b = clk_blink;
            return;
        end
        r1 = h1_1 && !h2_1;
        r2 = h1_2 && !h2_2;
        rp = h1_p && !h2_p;
        m_roll = 0;
        if (m_mode == 1 && r1) begin
            m_total = m_total + 1;
            if (m_total == 3600) begin
                m_total = 0;
                m_roll = 1;
            end
        end
        if (m_mode == 2 && r2) begin
            if (sel) m_total = (((m_total / 60) + 1) % 60) * 60 + (m_total % 60);
            else     m_total = (m_total / 60) * 60 + ((m_total % 60) + 1) % 60;
        end
        nm = m_mode;
        if (adj)              nm = 2;
        else if (m_mode == 2) nm = 0;
        else if (rp)          nm = (m_mode == 1) ? 0 : 1;
        m_bsec = (nm == 2) && !sel && m_b;
        m_bmin = (nm == 2) &&  sel && m_b;
        m_mode = nm;
        m_b = clk_blink;
        h2_1 = h1_1; h1_1 = clk_1Hz;
        h2_2 = h1_2; h1_2 = clk_2Hz;
        h2_p = h1_p; h1_p = pause_btn;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        if (rollover) roll_cnt++;
        chk("model.minutes",   int'(minutes),   m_total / 60);
        chk("model.seconds",   int'(seconds),   m_total % 60);
        chk("model.running",   int'(running),   int'(m_mode == 1));
        chk("model.blank_min", int'(blank_min), int'(m_bmin));
        chk("model.blank_sec", int'(blank_sec), int'(m_bsec));
        chk("model.rollover",  int'(rollover),  int'(m_roll));
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic tick1();
        clk_1Hz = 1'b1; step(); clk_1Hz = 1'b0; step();
    endtask

    task automatic pulse2();
        clk_2Hz = 1'b1; step(); clk_2Hz = 1'b0; step();
    endtask

    task automatic press();
        pause_btn = 1'b1; step(); pause_btn = 1'b0; step();
    endtask

    typedef struct {
        logic r, c1, c2, bl, pb, a, s;
        int   emin, esec;
        logic erun, ebmin, ebsec, eroll;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, c1, c2, bl, pb, a, s,
                                input int emin, esec, input logic erun, ebmin, ebsec, eroll);
        vec_t v;
        v.r = r; v.c1 = c1; v.c2 = c2; v.bl = bl; v.pb = pb; v.a = a; v.s = s;
        v.emin = emin; v.esec = esec;
        v.erun = erun; v.ebmin = ebmin; v.ebsec = ebsec; v.eroll = eroll;
        tbl.push_back(v);
    endfunction

    initial begin
        // Reset, then three 1 Hz edges while stopped: nothing moves.
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0);
        for (int k = 0; k < 3; k++) begin
            add(0,1,0,0,0,0,0, 0,0,0,0,0,0);
            add(0,1,0,0,0,0,0, 0,0,0,0,0,0);
            add(0,0,0,0,0,0,0, 0,0,0,0,0,0);
            add(0,0,0,0,0,0,0, 0,0,0,0,0,0);
        end
        // Adjust minutes: 1 Hz edges and a pause press are ignored.
        add(0,0,0,0,0,1,1, 0,0,0,0,0,0);
        for (int k = 0; k < 2; k++) begin
            add(0,1,0,0,0,1,1, 0,0,0,0,0,0);
            add(0,0,0,0,0,1,1, 0,0,0,0,0,0);
        end
        add(0,0,0,0,1,1,1, 0,0,0,0,0,0);
        add(0,0,0,0,1,1,1, 0,0,0,0,0,0);
        add(0,0,0,0,0,1,1, 0,0,0,0,0,0);
        add(0,0,0,0,0,1,1, 0,0,0,0,0,0);
        // Blink reaches the blank flags one cycle after it is sampled.
        add(0,0,0,1,0,1,1, 0,0,0,0,0,0);
        add(0,0,0,1,0,1,1, 0,0,0,1,0,0);
        add(0,0,0,0,0,1,1, 0,0,0,1,0,0);
        add(0,0,0,0,0,1,1, 0,0,0,0,0,0);
        add(0,0,0,1,0,1,0, 0,0,0,0,0,0);
        add(0,0,0,1,0,1,0, 0,0,0,0,1,0);
        add(0,0,0,0,0,1,0, 0,0,0,0,1,0);
        add(0,0,0,0,0,1,0, 0,0,0,0,0,0);
        // Leaving adjust lands in STOP.
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; clk_1Hz = tbl[i].c1; clk_2Hz = tbl[i].c2; clk_blink = tbl[i].bl;
            pause_btn = tbl[i].pb; adj = tbl[i].a; sel = tbl[i].s;
            step();
            chk($sformatf("vec%0d.minutes", i),   int'(minutes),   tbl[i].emin);
            chk($sformatf("vec%0d.seconds", i),   int'(seconds),   tbl[i].esec);
            chk($sformatf("vec%0d.running", i),   int'(running),   int'(tbl[i].erun));
            chk($sformatf("vec%0d.blank_min", i), int'(blank_min), int'(tbl[i].ebmin));
            chk($sformatf("vec%0d.blank_sec", i), int'(blank_sec), int'(tbl[i].ebsec));
            chk($sformatf("vec%0d.rollover", i),  int'(rollover),  int'(tbl[i].eroll));
        end
        rst = 1'b0; clk_1Hz = 0; clk_2Hz = 0; clk_blink = 0; pause_btn = 0; adj = 0; sel = 0;

        // Run 61 seconds, then freeze.
        do_reset();
        press();
        repeat (61) tick1();
        chk("run61.minutes", int'(minutes), 1);
        chk("run61.seconds", int'(seconds), 1);
        chk("run61.running", int'(running), 1);
        press();
        repeat (3) tick1();
        chk("frozen.minutes", int'(minutes), 1);
        chk("frozen.seconds", int'(seconds), 1);
        chk("frozen.running", int'(running), 0);

        // Preload 59:58 through adjust mode, then run across the wrap.
        do_reset();
        adj = 1'b1; sel = 1'b1; step();
        repeat (59) pulse2();
        sel = 1'b0;
        repeat (58) pulse2();
        chk("preload.minutes", int'(minutes), 59);
        chk("preload.seconds", int'(seconds), 58);
        adj = 1'b0; step();
        press();
        tick1();
        chk("wrap1.minutes", int'(minutes), 59);
        chk("wrap1.seconds", int'(seconds), 59);
        roll_cnt = 0;
        tick1();
        chk("wrap2.minutes", int'(minutes), 0);
        chk("wrap2.seconds", int'(seconds), 0);
        repeat (3) step();
        chk("wrap.rollover_cycles", roll_cnt, 1);

        // Seconds adjust wraps without carry; blank_sec tracks blink.
        do_reset();
        adj = 1'b1; sel = 1'b0; step();
        repeat (59) pulse2();
        chk("adjsec.seconds59", int'(seconds), 59);
        pulse2();
        chk("adjsec.seconds0", int'(seconds), 0);
        chk("adjsec.minutes", int'(minutes), 0);
        clk_blink = 1'b1; step(); step();
        chk("adjsec.blank_on", int'(blank_sec), 1);
        chk("adjsec.blank_min_off", int'(blank_min), 0);
        clk_blink = 1'b0; step(); step();
        chk("adjsec.blank_off", int'(blank_sec), 0);
        adj = 1'b0; step();

        // Reset mid-run with the 1 Hz level held high.
        do_reset();
        press();
        tick1(); tick1();
        clk_1Hz = 1'b1; step(); step();
        chk("hold.seconds", int'(seconds), 3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstpulse.seconds", int'(seconds), 0);
        chk("rstpulse.running", int'(running), 0);
        repeat (4) step();
        chk("after_rst.minutes", int'(minutes), 0);
        chk("after_rst.seconds", int'(seconds), 0);
        chk("after_rst.running", int'(running), 0);
        clk_1Hz = 1'b0;

        // Random stimulus against the model.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(3) == 0)  clk_1Hz   = ~clk_1Hz;
            if ($urandom_range(2) == 0)  clk_2Hz   = ~clk_2Hz;
            if ($urandom_range(7) == 0)  clk_blink = ~clk_blink;
            if ($urandom_range(9) == 0)  pause_btn = ~pause_btn;
            if ($urandom_range(59) == 0) adj       = ~adj;
            if ($urandom_range(19) == 0) sel       = ~sel;
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
